apb_timer_regs: RTL and testbench
=================================

APB_TIMER_REGS -- requirements
Module: apb_timer_regs

Interface
REQ-001 SHALL have parameter NCH, default 4, number of timer channels (1..16).
REQ-002 SHALL have parameter CW, default 16, counter data width in bits (8..32).
REQ-003 SHALL have parameter WAIT, default 2, APB wait states per access (0..7).
REQ-004 SHALL have port pclk  input  1  APB clock.
REQ-005 SHALL have port presetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports psel, penable, pwrite  input  1 each  APB control.
REQ-007 SHALL have port paddr  input  8  byte address; [7:4] channel, [3:0] offset.
REQ-008 SHALL have port pwdata  input  32  write data.
REQ-009 SHALL have port prdata  output  32  read data.
REQ-010 SHALL have ports pready, pslverr  output  1 each  APB response.
REQ-011 SHALL have ports ovf_trig, udf_trig  input  NCH each  per-channel timer event pulses.
REQ-012 SHALL have port tdr  output  NCH*CW  packed per-channel reload data.
REQ-013 SHALL have ports load, ud, en  output  NCH each  per-channel control bits.
REQ-014 SHALL have port cks  output  2*NCH  per-channel clock select.
REQ-015 SHALL have port clr_trig  output  2*NCH  per-channel {udf,ovf} set-acknowledge pulses.
REQ-016 SHALL have port irq  output  NCH  per-channel interrupt request.

Function
REQ-017 Offsets: 0x0 TDR (CW bits, upper bits read 0), 0x4 TCR, 0x8 TSR, 0xC TIER.
REQ-018 TCR bits: [7] load, [5] ud, [4] en, [1:0] cks; all other bits write-ignored and read 0.
REQ-019 TSR bits: [0] ovf, [1] udf; write-1-to-clear, writing 0 has no effect.
REQ-020 Wait counter: cleared in the setup phase (psel & !penable); increments each access-phase cycle; pready=1 when the count equals WAIT (WAIT=0 gives zero wait states).
REQ-021 pready SHALL be high for exactly one cycle per transfer; it SHALL be 0 whenever psel=0.
REQ-022 pslverr SHALL equal 1 only during the pready cycle when the channel is >= NCH, the offset is not in REQ-017, or paddr[1:0] != 0.
REQ-023 Register writes SHALL commit on the pready cycle with pwrite=1 and no error; erroring writes SHALL change no state.
REQ-024 prdata SHALL be valid in the pready cycle of a read and 0 in all other cycles, including error cycles.
REQ-025 If psel drops before pready, the transfer SHALL be abandoned: no write, counter cleared.
REQ-026 A trigger pulse SHALL set its flag next cycle and pulse the matching clr_trig bit for exactly one cycle.
REQ-027 A trigger and a W1C of the same flag in the same cycle: set wins, and clr_trig pulses.
REQ-028 Independent flags and channels SHALL update in the same cycle without interaction.
REQ-029 Outputs load/ud/en/cks/tdr SHALL be driven directly from register state with zero latency after commit.

Reset
REQ-030 On presetn=0 all registers, flags, the wait counter, pready, pslverr, prdata, clr_trig and irq SHALL go to 0 immediately.
REQ-031 Reset during a transfer SHALL abort it; the first transfer after release SHALL behave normally.

Configuration
REQ-032 Macro APB_TIMER_REGS_IRQ_EN defined: TIER [0] ovf_ie, [1] udf_ie; irq[n] = (ovf&ovf_ie)|(udf&udf_ie), combinational from registers.
REQ-033 Macro undefined: offset 0xC is unmapped (pslverr), no TIER storage, irq tied to 0.

Structure
REQ-034 Package apb_timer_regs_pkg SHALL hold offset constants, TCR/TSR/TIER bit positions and the error-decode helper.
REQ-035 Per-channel storage SHALL be one sub-module, timer_chan_regs, instantiated NCH times; APB handshake, decode and read mux stay in the top module.

Verification
REQ-036 WAIT=2, write 0x1234 to ch1 TDR (0x10) -> pready on the 3rd access cycle, tdr[31:16]=0x1234, other channels unchanged.
REQ-037 Write TCR ch0 0xFF, then read it -> read returns 0xB3; load=1, ud=1, en=1, cks=3.
REQ-038 Pulse ovf_trig[2] -> TSR ch2 reads 0x1, clr_trig[4] high for 1 cycle; write 0x1 to TSR in the same cycle as a second ovf pulse -> flag remains 1.
REQ-039 Access 0x50 with NCH=4, and 0x06 -> pslverr=1 with pready, prdata=0, no state change.
REQ-040 With IRQ_EN, TIER ch3=0x2, pulse udf_trig[3] -> irq[3]=1; W1C 0x2 -> irq[3]=0; without the macro irq stays 0.
REQ-041 Assert presetn=0 mid-access -> all outputs 0 asynchronously, and the next write completes normally.

Source files
------------

// File: rtl/apb_timer_regs_pkg.sv
// Shared constants and address-decode helper for the APB timer register block.
// The optional TIER register is selected by the APB_TIMER_REGS_IRQ_EN macro.
package apb_timer_regs_pkg;

  localparam logic [3:0] OffTdr  = 4'h0;
  localparam logic [3:0] OffTcr  = 4'h4;
  localparam logic [3:0] OffTsr  = 4'h8;
  localparam logic [3:0] OffTier = 4'hC;

  localparam int unsigned TcrLoadBit = 7;
  localparam int unsigned TcrUdBit   = 5;
  localparam int unsigned TcrEnBit   = 4;
  localparam int unsigned TcrCksLsb  = 0;
  localparam logic [7:0]  TcrMask    = 8'hB3;

  localparam int unsigned TsrOvfBit    = 0;
  localparam int unsigned TsrUdfBit    = 1;
  localparam int unsigned TierOvfIeBit = 0;
  localparam int unsigned TierUdfIeBit = 1;

  // High for channels beyond nch, misaligned addresses and unmapped offsets.
  function automatic logic addr_err(input logic [7:0] paddr, input int unsigned nch,
                                    input logic irq_en);
    logic off_bad;
    case (paddr[3:0])
      OffTdr, OffTcr, OffTsr: off_bad = 1'b0;
      OffTier:                off_bad = ~irq_en;
      default:                off_bad = 1'b1;
    endcase
    return (32'(paddr[7:4]) >= nch) || (paddr[1:0] != 2'b00) || off_bad;
  endfunction

endpackage

// File: rtl/apb_timer_regs_if.sv
// APB completer bus bundle for the timer register block.
interface apb_timer_regs_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/timer_chan_regs.sv
// Storage for one timer channel: TDR, TCR, TSR flags and (with APB_TIMER_REGS_IRQ_EN) TIER.
module timer_chan_regs
  import apb_timer_regs_pkg::*;
#(
    parameter int unsigned CW = 16
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          wr_tdr,
    input  logic          wr_tcr,
    input  logic          wr_tsr,
`ifdef APB_TIMER_REGS_IRQ_EN
    input  logic          wr_tier,
    output logic [1:0]    tier,
`endif
    input  logic [CW-1:0] tdr_wdata,
    input  logic [7:0]    ctl_wdata,
    input  logic          ovf_trig,
    input  logic          udf_trig,
    output logic [CW-1:0] tdr,
    output logic [7:0]    tcr,
    output logic [1:0]    tsr,
    output logic [1:0]    clr_trig,
    output logic          irq
);

    logic [CW-1:0] tdr_q, tdr_d;
    logic [7:0]    tcr_q, tcr_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic [1:0]    clr_q, clr_d;

    always_comb begin
        tdr_d = tdr_q;
        tcr_d = tcr_q;
        if (wr_tdr) tdr_d = tdr_wdata;
        if (wr_tcr) tcr_d = ctl_wdata & TcrMask;
        // A trigger in the same cycle as a clear keeps the flag set.
        ovf_d = ovf_trig | (ovf_q & ~(wr_tsr & ctl_wdata[TsrOvfBit]));
        udf_d = udf_trig | (udf_q & ~(wr_tsr & ctl_wdata[TsrUdfBit]));
        clr_d = {udf_trig, ovf_trig};
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tdr_q <= '0;
            tcr_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
            clr_q <= '0;
        end else begin
            tdr_q <= tdr_d;
            tcr_q <= tcr_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
            clr_q <= clr_d;
        end
    end

    assign tdr      = tdr_q;
    assign tcr      = tcr_q;
    assign tsr      = {udf_q, ovf_q};
    assign clr_trig = clr_q;

`ifdef APB_TIMER_REGS_IRQ_EN
    logic [1:0] tier_q, tier_d;

    always_comb begin
        tier_d = tier_q;
        if (wr_tier) tier_d = ctl_wdata[1:0];
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) tier_q <= '0;
        else          tier_q <= tier_d;
    end

    assign tier = tier_q;
    assign irq  = (ovf_q & tier_q[TierOvfIeBit]) | (udf_q & tier_q[TierUdfIeBit]);
`else
    assign irq = 1'b0;
`endif

endmodule

// File: rtl/apb_timer_regs.sv
// APB register front-end for NCH timer channels: wait states, decode and read mux.
// Define APB_TIMER_REGS_IRQ_EN to add the per-channel TIER register and irq outputs.
module apb_timer_regs
  import apb_timer_regs_pkg::*;
#(
    parameter int unsigned NCH  = 4,
    parameter int unsigned CW   = 16,
    parameter int unsigned WAIT = 2
) (
    input  logic                pclk,
    input  logic                presetn,
    apb_timer_regs_if.slave     bus,
    input  logic [NCH-1:0]      ovf_trig,
    input  logic [NCH-1:0]      udf_trig,
    output logic [NCH*CW-1:0]   tdr,
    output logic [NCH-1:0]      load,
    output logic [NCH-1:0]      ud,
    output logic [NCH-1:0]      en,
    output logic [2*NCH-1:0]    cks,
    output logic [2*NCH-1:0]    clr_trig,
    output logic [NCH-1:0]      irq
);

`ifdef APB_TIMER_REGS_IRQ_EN
    localparam logic IrqEn = 1'b1;
`else
    localparam logic IrqEn = 1'b0;
`endif

    logic [3:0]  cnt_q, cnt_d;
    logic        access, ready, err, commit;
    logic [3:0]  ch, off;
    logic [31:0] rd_data;

    logic [CW-1:0] chan_tdr [NCH];
    logic [7:0]    chan_tcr [NCH];
    logic [1:0]    chan_tsr [NCH];
`ifdef APB_TIMER_REGS_IRQ_EN
    logic [1:0]    chan_tier [NCH];
`endif

    // Counter parks at WAIT+1 after the ready cycle so pready cannot repeat.
    always_comb begin
        cnt_d = cnt_q;
        if (!bus.psel || !bus.penable) cnt_d = '0;
        else if (cnt_q <= 4'(WAIT))    cnt_d = cnt_q + 4'd1;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign ch     = bus.paddr[7:4];
    assign off    = bus.paddr[3:0];
    assign access = presetn & bus.psel & bus.penable;
    assign ready  = access & (cnt_q == 4'(WAIT));
    assign err    = addr_err(bus.paddr, NCH, IrqEn);
    assign commit = ready & bus.pwrite & ~err;

    for (genvar n = 0; n < NCH; n++) begin : g_chan
        logic sel;
        assign sel = commit & (ch == 4'(n));

        timer_chan_regs #(
            .CW(CW)
        ) u_chan (
            .pclk      (pclk),
            .presetn   (presetn),
            .wr_tdr    (sel & (off == OffTdr)),
            .wr_tcr    (sel & (off == OffTcr)),
            .wr_tsr    (sel & (off == OffTsr)),
`ifdef APB_TIMER_REGS_IRQ_EN
            .wr_tier   (sel & (off == OffTier)),
            .tier      (chan_tier[n]),
`endif
            .tdr_wdata (bus.pwdata[CW-1:0]),
            .ctl_wdata (bus.pwdata[7:0]),
            .ovf_trig  (ovf_trig[n]),
            .udf_trig  (udf_trig[n]),
            .tdr       (chan_tdr[n]),
            .tcr       (chan_tcr[n]),
            .tsr       (chan_tsr[n]),
            .clr_trig  (clr_trig[2*n +: 2]),
            .irq       (irq[n])
        );

        assign tdr[n*CW +: CW] = chan_tdr[n];
        assign load[n]         = chan_tcr[n][TcrLoadBit];
        assign ud[n]           = chan_tcr[n][TcrUdBit];
        assign en[n]           = chan_tcr[n][TcrEnBit];
        assign cks[2*n +: 2]   = chan_tcr[n][TcrCksLsb +: 2];
    end

    always_comb begin
        rd_data = '0;
        for (int n = 0; n < NCH; n++) begin
            if (ch == 4'(n)) begin
                case (off)
                    OffTdr:  rd_data = 32'(chan_tdr[n]);
                    OffTcr:  rd_data = 32'(chan_tcr[n]);
                    OffTsr:  rd_data = 32'(chan_tsr[n]);
`ifdef APB_TIMER_REGS_IRQ_EN
                    OffTier: rd_data = 32'(chan_tier[n]);
`endif
                    default: rd_data = '0;
                endcase
            end
        end
    end

    assign bus.pready  = ready;
    assign bus.pslverr = ready & err;
    assign bus.prdata  = (ready & ~bus.pwrite & ~err) ? rd_data : '0;

endmodule

// File: tb/tb_apb_timer_regs.sv
// Randomized self-checking bench for apb_timer_regs against a register-level model.
// Expectations follow APB_TIMER_REGS_IRQ_EN if defined at compile time.
module tb_apb_timer_regs;
  localparam int unsigned NCH  = 4;
  localparam int unsigned CW   = 16;
  localparam int unsigned WAIT = 2;
`ifdef APB_TIMER_REGS_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  logic [NCH-1:0] ovf_trig = '0, udf_trig = '0;
  logic [NCH*CW-1:0] tdr;
  logic [NCH-1:0] load, ud, en, irq;
  logic [2*NCH-1:0] cks, clr_trig;

  apb_timer_regs_if bus();

  apb_timer_regs #(.NCH(NCH), .CW(CW), .WAIT(WAIT)) dut (
    .pclk(pclk), .presetn(presetn), .bus(bus.slave),
    .ovf_trig(ovf_trig), .udf_trig(udf_trig), .tdr(tdr), .load(load), .ud(ud), .en(en),
    .cks(cks), .clr_trig(clr_trig), .irq(irq)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  // Register-level reference model
  logic [31:0] m_tdr [NCH];
  logic [7:0]  m_tcr [NCH];
  bit m_ovf [NCH], m_udf [NCH], m_oie [NCH], m_uie [NCH];

  task automatic model_reset();
    for (int n = 0; n < NCH; n++) begin
      m_tdr[n] = '0; m_tcr[n] = '0;
      m_ovf[n] = 0; m_udf[n] = 0; m_oie[n] = 0; m_uie[n] = 0;
    end
  endtask

  function automatic bit exp_err(input logic [7:0] a);
    int ch = int'(a[7:4]);
    int off = int'(a[3:0]);
    if (ch >= NCH) return 1;
    if (off == 0 || off == 4 || off == 8) return 0;
    if (off == 12) return !IRQ;
    return 1;
  endfunction

  function automatic logic [31:0] exp_read(input logic [7:0] a);
    int ch = int'(a[7:4]);
    if (exp_err(a)) return 0;
    case (int'(a[3:0]))
      0: return m_tdr[ch];
      4: return {24'd0, m_tcr[ch]};
      8: return {30'd0, m_udf[ch], m_ovf[ch]};
      default: return {30'd0, m_uie[ch], m_oie[ch]};
    endcase
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [31:0] d);
    int ch = int'(a[7:4]);
    case (int'(a[3:0]))
      0: m_tdr[ch] = d % (64'd1 << CW);
      4: m_tcr[ch] = d[7:0] & 8'b1011_0011;
      8: begin
        if (d[0]) m_ovf[ch] = 0;
        if (d[1]) m_udf[ch] = 0;
      end
      default: begin m_oie[ch] = d[0]; m_uie[ch] = d[1]; end
    endcase
  endtask

  task automatic model_trig(input logic [NCH-1:0] ot, input logic [NCH-1:0] ut);
    for (int n = 0; n < NCH; n++) begin
      if (ot[n]) m_ovf[n] = 1;
      if (ut[n]) m_udf[n] = 1;
    end
  endtask

  function automatic logic [2*NCH-1:0] exp_clr(input logic [NCH-1:0] ot,
                                               input logic [NCH-1:0] ut);
    logic [2*NCH-1:0] v = '0;
    for (int n = 0; n < NCH; n++) begin
      v[2*n] = ot[n];
      v[2*n+1] = ut[n];
    end
    return v;
  endfunction

  task automatic check_outputs(input string name);
    logic [NCH*CW-1:0] e_tdr = '0;
    logic [NCH-1:0] e_load = '0, e_ud = '0, e_en = '0, e_irq = '0;
    logic [2*NCH-1:0] e_cks = '0;
    for (int n = 0; n < NCH; n++) begin
      e_tdr[n*CW +: CW] = m_tdr[n][CW-1:0];
      e_load[n] = m_tcr[n][7];
      e_ud[n] = m_tcr[n][5];
      e_en[n] = m_tcr[n][4];
      e_cks[2*n +: 2] = m_tcr[n][1:0];
      e_irq[n] = IRQ && ((m_ovf[n] && m_oie[n]) || (m_udf[n] && m_uie[n]));
    end
    checks++;
    if (tdr !== e_tdr || load !== e_load || ud !== e_ud || en !== e_en || cks !== e_cks
        || irq !== e_irq) begin
      errors++;
      $display("FAIL %s outputs: got tdr=%h load=%b ud=%b en=%b cks=%b irq=%b, want tdr=%h load=%b ud=%b en=%b cks=%b irq=%b",
               name, tdr, load, ud, en, cks, irq, e_tdr, e_load, e_ud, e_en, e_cks, e_irq);
    end
  endtask

  // One APB transfer; ot/ut pulse triggers into the commit edge.
  task automatic apb(input bit wr, input logic [7:0] a, input logic [31:0] d,
                     input logic [NCH-1:0] ot, input logic [NCH-1:0] ut,
                     output logic [31:0] rdata, output logic err, output int waits);
    bit done = 0;
    bit e = exp_err(a);
    @(posedge pclk); #1;
    bus.psel = 1; bus.penable = 0; bus.pwrite = wr; bus.paddr = a; bus.pwdata = d;
    @(negedge pclk);
    checks++;
    if (bus.pready !== 1'b0 || bus.prdata !== 32'd0) begin
      errors++;
      $display("FAIL setup_phase: got pready=%b prdata=%h, want 0 0", bus.pready, bus.prdata);
    end
    @(posedge pclk); #1;
    bus.penable = 1;
    waits = 0;
    rdata = 'x; err = 'x;
    while (!done) begin
      @(negedge pclk);
      if (bus.pready === 1'b1) begin
        rdata = bus.prdata; err = bus.pslverr; done = 1;
        ovf_trig = ot; udf_trig = ut;
      end else begin
        checks++;
        if (bus.prdata !== 32'd0 || bus.pslverr !== 1'b0) begin
          errors++;
          $display("FAIL wait_cycle: got prdata=%h pslverr=%b, want 0 0", bus.prdata, bus.pslverr);
        end
        waits++;
        if (waits > 20) begin
          errors++;
          $display("FAIL pready_timeout: got no pready in 20 cycles, want pready after %0d", WAIT);
          done = 1;
        end
      end
    end
    @(posedge pclk); #1;
    bus.psel = 0; bus.penable = 0;
    ovf_trig = '0; udf_trig = '0;
    if (wr && !e) model_write(a, d);
    model_trig(ot, ut);
    checks++;
    if (bus.pready !== 1'b0 || clr_trig !== exp_clr(ot, ut)) begin
      errors++;
      $display("FAIL post_transfer: got pready=%b clr_trig=%b, want 0 %b",
               bus.pready, clr_trig, exp_clr(ot, ut));
    end
  endtask

  task automatic test_reset();
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = '0; bus.pwdata = '0;
    model_reset();
    repeat (3) @(negedge pclk);
    checks++;
    if (bus.pready !== 0 || bus.pslverr !== 0 || bus.prdata !== 0 || clr_trig !== 0) begin
      errors++;
      $display("FAIL reset_bus: got pready=%b pslverr=%b prdata=%h clr=%b, want all 0",
               bus.pready, bus.pslverr, bus.prdata, clr_trig);
    end
    check_outputs("reset");
    presetn = 1;
  endtask

  task automatic test_tdr_write();
    logic [31:0] rd; logic err; int w;
    apb(1, 8'h10, 32'h0000_1234, '0, '0, rd, err, w);
    checks++;
    if (w != WAIT || err !== 0 || tdr[31:16] !== 16'h1234 || tdr[15:0] !== 16'h0) begin
      errors++;
      $display("FAIL tdr_write: got waits=%0d err=%b tdr=%h, want %0d 0 ch1=1234", w, err, tdr, WAIT);
    end
    check_outputs("tdr_write");
  endtask

  task automatic test_tcr();
    logic [31:0] rd; logic err; int w;
    apb(1, 8'h04, 32'hFF, '0, '0, rd, err, w);
    apb(0, 8'h04, 32'h0, '0, '0, rd, err, w);
    checks++;
    if (rd !== 32'hB3 || load[0] !== 1 || ud[0] !== 1 || en[0] !== 1 || cks[1:0] !== 2'd3) begin
      errors++;
      $display("FAIL tcr_rw: got rd=%h load=%b ud=%b en=%b cks=%b, want b3 1 1 1 11",
               rd, load[0], ud[0], en[0], cks[1:0]);
    end
    check_outputs("tcr");
  endtask

  task automatic test_trig();
    logic [31:0] rd; logic err; int w;
    @(posedge pclk); #1;
    ovf_trig = 4'b0100;
    @(posedge pclk); #1;
    ovf_trig = '0;
    model_trig(4'b0100, '0);
    checks++;
    if (clr_trig !== 8'b0001_0000) begin
      errors++;
      $display("FAIL clr_pulse: got %b, want 00010000", clr_trig);
    end
    @(posedge pclk); #1;
    checks++;
    if (clr_trig !== 8'b0) begin
      errors++;
      $display("FAIL clr_one_cycle: got %b, want 00000000", clr_trig);
    end
    apb(0, 8'h28, 0, '0, '0, rd, err, w);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL tsr_set: got %h, want 1", rd); end
    apb(1, 8'h28, 32'h1, 4'b0100, '0, rd, err, w);
    apb(0, 8'h28, 0, '0, '0, rd, err, w);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL set_wins: got %h, want 1", rd); end
    apb(1, 8'h28, 32'h0, '0, 4'b0100, rd, err, w);
    apb(1, 8'h28, 32'h2, '0, '0, rd, err, w);
    apb(0, 8'h28, 0, '0, '0, rd, err, w);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL w1c_udf_only: got %h, want 1", rd); end
    apb(1, 8'h28, 32'h1, '0, '0, rd, err, w);
    apb(0, 8'h28, 0, '0, '0, rd, err, w);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL w1c_ovf: got %h, want 0", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int w;
    logic [7:0] addrs [4];
    addrs = '{8'h50, 8'h06, 8'hF3, 8'h1E};
    for (int i = 0; i < 4; i++) begin
      apb(1, addrs[i], 32'hFFFF_FFFF, '0, '0, rd, err, w);
      checks++;
      if (err !== 1 || rd !== 0 || w != WAIT) begin
        errors++;
        $display("FAIL err_write %h: got err=%b rd=%h waits=%0d, want 1 0 %0d",
                 addrs[i], err, rd, w, WAIT);
      end
      apb(0, addrs[i], 0, '0, '0, rd, err, w);
      checks++;
      if (err !== 1 || rd !== 0) begin
        errors++;
        $display("FAIL err_read %h: got err=%b rd=%h, want 1 0", addrs[i], err, rd);
      end
      check_outputs("err_nochange");
    end
  endtask

  task automatic test_irq();
    logic [31:0] rd; logic err; int w;
    apb(1, 8'h3C, 32'h2, '0, '0, rd, err, w);
    apb(1, 8'h38, 32'h0, '0, 4'b1000, rd, err, w);
`ifdef APB_TIMER_REGS_IRQ_EN
    checks++;
    if (err !== 0 || irq[3] !== 1) begin
      errors++; $display("FAIL irq_set: got err=%b irq3=%b, want 0 1", err, irq[3]);
    end
`else
    checks++;
    if (irq !== '0) begin errors++; $display("FAIL irq_tied: got %b, want 0", irq); end
`endif
    check_outputs("irq_set");
    apb(1, 8'h38, 32'h2, '0, '0, rd, err, w);
    checks++;
    if (irq[3] !== 0) begin errors++; $display("FAIL irq_clear: got %b, want 0", irq[3]); end
    check_outputs("irq_clear");
  endtask

  task automatic test_random();
    logic [31:0] rd, exp; logic err; int w;
    logic [7:0] a; logic [31:0] d; bit wr; logic [NCH-1:0] ot, ut;
    for (int i = 0; i < 60; i++) begin
      a[7:4] = 4'($urandom_range(0, 5));
      a[3:0] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                            : {2'($urandom_range(0, 3)), 2'b00};
      wr = 1'($urandom_range(0, 1));
      d = $urandom;
      ot = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
      ut = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
      exp = wr ? 32'd0 : exp_read(a);
      apb(wr, a, d, ot, ut, rd, err, w);
      checks++;
      if (err !== exp_err(a) || rd !== exp || w != WAIT) begin
        errors++;
        $display("FAIL random %0d a=%h wr=%b: got err=%b rd=%h waits=%0d, want %b %h %0d",
                 i, a, wr, err, rd, w, exp_err(a), exp, WAIT);
      end
      check_outputs("random");
    end
  endtask

  task automatic test_abandon();
    logic [31:0] rd; logic err; int w;
    @(posedge pclk); #1;
    bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = 8'h00; bus.pwdata = 32'hBEEF;
    @(posedge pclk); #1;
    bus.penable = 1;
    @(posedge pclk); #1;
    bus.psel = 0; bus.penable = 0;
    @(negedge pclk);
    checks++;
    if (bus.pready !== 0) begin errors++; $display("FAIL abandon_pready: got %b, want 0", bus.pready); end
    check_outputs("abandon");
    apb(0, 8'h00, 0, '0, '0, rd, err, w);
    checks++;
    if (w != WAIT || rd !== exp_read(8'h00)) begin
      errors++;
      $display("FAIL after_abandon: got waits=%0d rd=%h, want %0d %h", w, rd, WAIT, exp_read(8'h00));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int w;
    @(posedge pclk); #1;
    bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = 8'h20; bus.pwdata = 32'h5A5A;
    @(posedge pclk); #1;
    bus.penable = 1;
    @(posedge pclk); #2;
    presetn = 0;
    #1;
    checks++;
    if (bus.pready !== 0 || bus.pslverr !== 0 || bus.prdata !== 0 || tdr !== '0 || load !== 0
        || ud !== 0 || en !== 0 || cks !== 0 || clr_trig !== 0 || irq !== 0) begin
      errors++;
      $display("FAIL async_reset: got pready=%b prdata=%h tdr=%h tcr=%b%b%b%b clr=%b irq=%b, want 0",
               bus.pready, bus.prdata, tdr, load, ud, en, cks, clr_trig, irq);
    end
    bus.psel = 0; bus.penable = 0;
    model_reset();
    @(negedge pclk);
    presetn = 1;
    apb(1, 8'h20, 32'h5A5A, '0, '0, rd, err, w);
    checks++;
    if (w != WAIT || err !== 0) begin
      errors++; $display("FAIL post_reset_write: got waits=%0d err=%b, want %0d 0", w, err, WAIT);
    end
    check_outputs("post_reset");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish before 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tdr_write();
    test_tcr();
    test_trig();
    test_errors();
    test_irq();
    test_random();
    test_abandon();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
